// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
// Decode resolves branches and jumps early, using the equality comparator.
// The redirected PC shows up on pc_f one cycle later.
// The wrong-path instruction already fetched is squashed into a nop.
// Saturating redirect and stall counters are kept for performance debug.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             branch_d,
    input  logic             equal_d,
    input  logic             jump_d,
    input  logic [31:0]      signimm_d,
    input  logic [31:0]      instr_f,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pcplus4_d,
    output logic             pcsrc_d,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_d_reg;
    logic [31:0] pcplus4_d_reg;
    logic [31:0] pcplus4_f;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        redirect;
    logic [1:0]  cnt_inc;

    // Next-PC selection: a jump beats a taken branch, and either beats sequential fetch
    always_comb begin
        pcplus4_f     = pc_reg + 32'd4;
        branch_target = pcplus4_d_reg + (signimm_d << 2);
        jump_target   = {pcplus4_d_reg[31:28], instr_d_reg[25:0], 2'b00};
        pcsrc_d       = branch_d & equal_d;
        redirect      = pcsrc_d | jump_d;
        if (jump_d) begin
            pc_next = jump_target;
        end else if (pcsrc_d) begin
            pc_next = branch_target;
        end else begin
            pc_next = pcplus4_f;
        end
    end

    // PC register
    // While stalled it holds its value. The redirecting instruction stays in decode,
    // so its redirect is applied on the first cycle without a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (!stall_f) begin
            pc_reg <= pc_next;
        end
    end

    // IF/ID register
    // A redirect squashes the fetched instruction into a nop.
    // The squash only happens when the register is enabled, so a stalled register is never cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d_reg   <= 32'd0;
            pcplus4_d_reg <= 32'd0;
        end else if (!stall_d) begin
            if (redirect) begin
                instr_d_reg   <= 32'd0;
                pcplus4_d_reg <= 32'd0;
            end else begin
                instr_d_reg   <= instr_f;
                pcplus4_d_reg <= pcplus4_f;
            end
        end
    end

    // Counter 0: redirects actually applied (PC not stalled). Counter 1: stall_f cycles.
    assign cnt_inc[0] = redirect & ~stall_f;
    assign cnt_inc[1] = stall_f;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : cnt_g
            logic [CNT_W-1:0] cnt_reg;

            // Saturating event counter: sticks at all-ones instead of wrapping
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            if (gi == 0) begin : redirect_out_g
                assign redirect_cnt = cnt_reg;
            end else begin : stall_out_g
                assign stall_cnt = cnt_reg;
            end
        end
    endgenerate

    assign pc_f      = pc_reg;
    assign instr_d   = instr_d_reg;
    assign pcplus4_d = pcplus4_d_reg;

endmodule
